pipeline_stage_memory: RTL

//  Memory-access stage between the execution stage and the writeback stage.

---
 rtl/pipeline_stage_memory.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_stage_memory.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding and registers the writeback result.
module pipeline_stage_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  input  logic [1:0]                in_size,
  input  logic                      in_sign_ext,
  input  logic [DATA_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REG_ID_WIDTH-1:0]   in_reg_write_id,
  input  logic [DATA_WIDTH-1:0]     in_reg_data,
  output logic                      stall_from_memory,
  output logic                      dm_req,
  output logic                      dm_we,
  output logic [DATA_WIDTH-1:0]     dm_addr,
  output logic [DATA_WIDTH/8-1:0]   dm_be,
  output logic [DATA_WIDTH-1:0]     dm_wdata,
  input  logic [DATA_WIDTH-1:0]     dm_rdata,
  input  logic                      dm_ack,
  output logic                      out_valid,
  output logic                      out_fault,
  output logic [REG_ID_WIDTH-1:0]   out_reg_write_id,
  output logic [DATA_WIDTH-1:0]     out_reg_data,
  output logic [REG_ID_WIDTH-1:0]   fwd_reg_id,
  output logic                      fwd_data_ready,
  output logic [DATA_WIDTH-1:0]     fwd_data
);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic                    we;
    logic [1:0]              size;
    logic                    sign;
    logic [DATA_WIDTH-1:0]   addr;
    logic [LANES-1:0]        be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [REG_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   data;
  } req_t;

  state_t state;
  req_t   r;

  logic mem_op, fault;
  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign fault  = mem_op & ((in_mem_read & in_mem_write) |
                            (in_size == 2'b11) |
                            ((in_size == 2'b01) & in_addr[0]) |
                            ((in_size == 2'b10) & (in_addr[1:0] != 2'b00)));

  // Byte enables and replicated write data are formed per lane before latching.
  logic [LANES-1:0]      st_be;
  logic [LANES-1:0][7:0] st_wdata;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic       be_l;
    logic [7:0] wd_l;
    always_comb begin
      be_l = 1'b1;
      wd_l = in_store_data[8*i +: 8];
      case (in_size)
        2'b00: begin
          be_l = (in_addr[1:0] == 2'(i));
          wd_l = in_store_data[7:0];
        end
        2'b01: begin
          be_l = (in_addr[1] == (i >= 2));
          wd_l = in_store_data[8*(i%2) +: 8];
        end
        default: ;
      endcase
    end
    assign st_be[i]    = be_l;
    assign st_wdata[i] = wd_l;
  end

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  always_comb begin
    case (r.addr[1:0])
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = r.addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r.size)
      2'b00:   ld_data = {{(DATA_WIDTH-8){r.sign & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(DATA_WIDTH-16){r.sign & ld_half[15]}}, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      r                <= '0;
      out_valid        <= 1'b0;
      out_fault        <= 1'b0;
      out_reg_write_id <= '0;
      out_reg_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !fault) begin
            r.we      <= in_mem_write;
            r.size    <= in_size;
            r.sign    <= in_sign_ext;
            r.addr    <= in_addr;
            r.be      <= st_be;
            r.wdata   <= st_wdata;
            r.id      <= in_reg_write_id;
            r.data    <= in_reg_data;
            state     <= ACCESS;
            out_valid <= 1'b0;
            out_fault <= 1'b0;
          end else begin
            out_valid        <= in_valid;
            out_fault        <= fault;
            out_reg_write_id <= fault ? '0 : in_reg_write_id;
            out_reg_data     <= in_reg_data;
          end
        end
        ACCESS: begin
          // Without ack a bubble goes downstream while upstream is held.
          if (dm_ack) begin
            state            <= IDLE;
            out_valid        <= 1'b1;
            out_fault        <= 1'b0;
            out_reg_write_id <= r.id;
            out_reg_data     <= r.we ? r.data : ld_data;
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_req   = (state == ACCESS);
  assign dm_we    = dm_req & r.we;
  assign dm_addr  = dm_req ? {r.addr[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dm_be    = dm_req ? r.be : '0;
  assign dm_wdata = dm_req ? r.wdata : '0;

  // Gated by reset so the stall drops the instant reset asserts.
  assign stall_from_memory = reset & ((state == IDLE) ? (mem_op & ~fault) : ~dm_ack);

  assign fwd_reg_id     = out_valid ? out_reg_write_id : '0;
  assign fwd_data       = out_valid ? out_reg_data : '0;
  assign fwd_data_ready = 1'b1;
endmodule
